// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: synchronises and edge-detects NUM_SRC sources,
// latches them as pending and drives a single prioritised I_Req/IACK handshake to the core.
module irq_controller #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               I_Req,
    input  logic               IACK,
    input  logic [31:0]        Data_addr,
    input  logic [31:0]        Wdata,
    input  logic [3:0]         we,
    output logic [31:0]        Rdata,
    output logic               hit
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_ENABLE  = 2'd1;
    localparam logic [1:0] OFF_CLAIM   = 2'd2;
    localparam logic [1:0] OFF_EOI     = 2'd3;

    state_t             r_state;
    state_t             w_state_next;

    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_s3;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic [4:0]         r_claim_id;
    logic               r_claim_valid;
    logic               r_ireq;

    logic [1:0]         w_offset;
    logic               w_wr;
    logic               w_wr_pending;
    logic               w_wr_enable;
    logic               w_wr_eoi;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clear;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_active;
    logic               w_any;
    logic [4:0]         w_sel;
    logic               w_claim_load;
    logic               w_ack;
    logic               w_eoi_done;
    logic               w_ireq_next;
    logic               w_unused_bits;

    // Bus decode: any nonzero byte enable is a full-word write.
    assign hit          = (Data_addr[31:4] == BASE_ADDR[31:4]);
    assign w_offset     = Data_addr[3:2];
    assign w_wr         = hit && (we != 4'b0000);
    assign w_wr_pending = w_wr && (w_offset == OFF_PENDING);
    assign w_wr_enable  = w_wr && (w_offset == OFF_ENABLE);
    assign w_wr_eoi     = w_wr && (w_offset == OFF_EOI);
    assign w_unused_bits = ^{Data_addr[1:0], Wdata[31:NUM_SRC]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= irq_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A fresh edge wins over a W1C or acknowledge clear landing on the same bit.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_rise[gi]         = r_s2[gi] & ~r_s3[gi];
            assign w_clear[gi]        = (w_wr_pending & Wdata[gi]) |
                                        (w_ack && (r_claim_id == 5'(gi)));
            assign w_pending_next[gi] = w_rise[gi] | (r_pending[gi] & ~w_clear[gi]);
            assign w_active[gi]       = r_pending[gi] & r_enable[gi];
        end
    endgenerate

    assign w_any = |w_active;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_enable  <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr_enable) begin
                r_enable <= Wdata[NUM_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ireq        <= 1'b0;
            r_claim_id    <= '0;
            r_claim_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ireq  <= w_ireq_next;
            if (w_claim_load) begin
                r_claim_id <= w_sel;
            end
            if (w_ack) begin
                r_claim_valid <= 1'b1;
            end else if (w_eoi_done) begin
                r_claim_valid <= 1'b0;
            end
        end
    end

    // REQ deliberately ignores later enable/pending changes; the claim may turn out spurious.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (IACK) begin
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_wr_eoi) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_claim_load = 1'b0;
        w_ack        = 1'b0;
        w_eoi_done   = 1'b0;
        case (r_state)
            ST_IDLE:    w_claim_load = w_any;
            ST_REQ:     w_ack        = IACK;
            ST_SERVICE: w_eoi_done   = w_wr_eoi;
            default:    ;
        endcase
        w_ireq_next = (w_state_next == ST_REQ);
    end

    assign I_Req = r_ireq;

    always_comb begin
        Rdata = '0;
        if (hit) begin
            case (w_offset)
                OFF_PENDING: Rdata = {{(32-NUM_SRC){1'b0}}, r_pending};
                OFF_ENABLE:  Rdata = {{(32-NUM_SRC){1'b0}}, r_enable};
                OFF_CLAIM:   Rdata = {r_claim_valid, 26'd0, r_claim_id};
                default:     Rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and scripted bench for irq_controller, checked every cycle against an
// event-level reference model (sample history, pending set, service mode).
`timescale 1ns/1ps
module tb_irq_controller;

    localparam int          NUM  = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic            clk = 1'b0;
    logic            reset;
    logic [NUM-1:0]  irq_src;
    logic            I_Req;
    logic            IACK;
    logic [31:0]     Data_addr;
    logic [31:0]     Wdata;
    logic [3:0]      we;
    logic [31:0]     Rdata;
    logic            hit;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 = waiting, 1 = requesting, 2 = in service.
    logic [NUM-1:0] m_pend;
    logic [NUM-1:0] m_en;
    int             m_mode;
    int             m_id;
    logic           m_valid;
    logic [NUM-1:0] m_hist[$];

    irq_controller #(.NUM_SRC(NUM), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .I_Req(I_Req), .IACK(IACK),
        .Data_addr(Data_addr), .Wdata(Wdata), .we(we), .Rdata(Rdata), .hit(hit)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_en);
            2'd2:    return {m_valid, 26'd0, 5'(m_id)};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lowest(input logic [NUM-1:0] v);
        for (int i = 0; i < NUM; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_mode = 0; m_id = 0; m_valid = 1'b0;
        m_hist.delete();
    endtask

    // A source value sampled two edges ago that was low three edges ago becomes pending now.
    task automatic model_edge();
        logic [NUM-1:0] set, clr, two_ago, three_ago;
        logic wr;
        int n;
        n = m_hist.size();
        two_ago   = (n >= 2) ? m_hist[n-2] : '0;
        three_ago = (n >= 3) ? m_hist[n-3] : '0;
        set = two_ago & ~three_ago;
        wr  = m_hit(Data_addr) && (we != 4'd0);
        clr = '0;
        if (wr && Data_addr[3:2] == 2'd0) clr = clr | Wdata[NUM-1:0];
        if (m_mode == 1 && IACK) clr[m_id] = 1'b1;
        case (m_mode)
            0: if ((m_pend & m_en) != '0) begin m_id = lowest(m_pend & m_en); m_mode = 1; end
            1: if (IACK) begin m_valid = 1'b1; m_mode = 2; end
            default: if (wr && Data_addr[3:2] == 2'd3) begin m_valid = 1'b0; m_mode = 0; end
        endcase
        m_pend = (m_pend & ~clr) | set;
        if (wr && Data_addr[3:2] == 2'd1) m_en = Wdata[NUM-1:0];
        m_hist.push_back(irq_src);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
    endtask

    // One clock: drive, compare outputs against the model, advance model and DUT.
    task automatic cycle(input logic [NUM-1:0] src, input logic [31:0] addr,
                         input logic [3:0] w, input logic [31:0] wd, input logic ack);
        irq_src = src; Data_addr = addr; we = w; Wdata = wd; IACK = ack;
        #1;
        chk("hit", 32'(hit), 32'(m_hit(addr)));
        chk("rdata", Rdata, m_rdata(addr));
        chk("ireq", 32'(I_Req), 32'(m_mode == 1));
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [NUM-1:0] src, input int n);
        for (int i = 0; i < n; i++) cycle(src, BASE, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Data_addr = addr; we = 4'd0;
        #1;
        chk(tag, Rdata, exp);
    endtask

    task automatic do_reset(input logic [NUM-1:0] src);
        irq_src = src; we = 4'd0; IACK = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_ireq", 32'(I_Req), 32'd0);
        expect_rd("rst_pend", BASE + 32'd0, 32'd0);
        expect_rd("rst_en", BASE + 32'd4, 32'd0);
        expect_rd("rst_claim", BASE + 32'd8, 32'd0);
        expect_rd("rst_eoi", BASE + 32'd12, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM-1:0] src, tog;
        logic [31:0] addr;
        int r;
        irq_src = '0; IACK = 1'b0; Data_addr = '0; Wdata = '0; we = '0; reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset('0);
        expect_rd("nohit_rd", 32'h0000_2000, 32'd0);
        chk("nohit", 32'(hit), 32'd0);

        // Single source through the full handshake.
        cycle('0, BASE + 4, 4'hF, 32'h05, 1'b0);
        cycle(8'h04, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 2);
        expect_rd("p2_pend", BASE, 32'h04);
        chk("p2_noreq", 32'(I_Req), 32'd0);
        idle('0, 1);
        chk("p2_req", 32'(I_Req), 32'd1);
        cycle('0, BASE + 8, 4'd0, 32'd0, 1'b1);
        chk("p2_ackdrop", 32'(I_Req), 32'd0);
        expect_rd("p2_claim", BASE + 8, 32'h8000_0002);
        expect_rd("p2_pend0", BASE, 32'h0);
        cycle('0, BASE + 12, 4'h1, 32'd0, 1'b0);
        expect_rd("p2_eoi", BASE + 8, 32'h0000_0002);

        // Two simultaneous sources: lower index first.
        cycle('0, BASE + 4, 4'hF, 32'hFF, 1'b0);
        cycle(8'h22, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 3);
        expect_rd("p3_id1", BASE + 8, 32'h0000_0001);
        cycle('0, BASE, 4'd0, 32'd0, 1'b1);
        cycle('0, BASE + 12, 4'h2, 32'd0, 1'b0);
        idle('0, 1);
        chk("p3_req2", 32'(I_Req), 32'd1);
        expect_rd("p3_id5", BASE + 8, 32'h0000_0005);
        cycle('0, BASE, 4'd0, 32'd0, 1'b1);
        cycle('0, BASE + 12, 4'hF, 32'd0, 1'b0);

        // Masked source, W1C, then unmask.
        cycle('0, BASE + 4, 4'hF, 32'h00, 1'b0);
        cycle(8'h08, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 3);
        expect_rd("p4_pend", BASE, 32'h08);
        chk("p4_noreq", 32'(I_Req), 32'd0);
        cycle('0, BASE, 4'h4, 32'h08, 1'b0);
        cycle('0, BASE + 4, 4'hF, 32'h08, 1'b0);
        idle('0, 2);
        chk("p4_w1c_noreq", 32'(I_Req), 32'd0);
        cycle(8'h08, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 2);
        cycle('0, BASE + 4, 4'hF, 32'h08, 1'b0);
        cycle('0, BASE, 4'd0, 32'd0, 1'b0);
        chk("p4_req", 32'(I_Req), 32'd1);
        cycle('0, BASE, 4'd0, 32'd0, 1'b1);
        cycle('0, BASE + 12, 4'hF, 32'd0, 1'b0);

        // New edge during service, then edge coinciding with the acknowledge clear.
        cycle('0, BASE + 4, 4'hF, 32'h01, 1'b0);
        cycle(8'h01, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 3);
        cycle('0, BASE, 4'd0, 32'd0, 1'b1);
        cycle(8'h01, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 3);
        expect_rd("p5_pend", BASE, 32'h01);
        chk("p5_blocked", 32'(I_Req), 32'd0);
        cycle('0, BASE + 12, 4'hF, 32'd0, 1'b0);
        idle('0, 1);
        chk("p5_rereq", 32'(I_Req), 32'd1);
        cycle(8'h01, BASE, 4'd0, 32'd0, 1'b0);
        idle('0, 1);
        cycle('0, BASE, 4'd0, 32'd0, 1'b1);
        expect_rd("p5_setwins", BASE, 32'h01);
        cycle('0, BASE + 12, 4'hF, 32'd0, 1'b0);
        idle('0, 1);
        chk("p6_req", 32'(I_Req), 32'd1);

        // Reset mid-request with source held high through release.
        do_reset(8'h01);
        idle(8'h01, 3);
        expect_rd("p6_once", BASE, 32'h01);
        cycle(8'h01, BASE, 4'hF, 32'h01, 1'b0);
        idle(8'h01, 4);
        expect_rd("p6_nomore", BASE, 32'h00);

        // Random traffic.
        src = 8'h01;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset(src);
            tog = '0;
            for (int b = 0; b < NUM; b++) tog[b] = ($urandom_range(0, 5) == 0);
            src = src ^ tog;
            r = $urandom_range(0, 9);
            if (r < 8)       addr = BASE + 32'($urandom_range(0, 15));
            else if (r == 8) addr = 32'h0000_2000;
            else             addr = BASE + 32'd16;
            cycle(src, addr,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
